// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption engine: accepts one plaintext/key block, runs the initial
// AddRoundKey plus ten rounds (COLS_PER_CYCLE columns per clock), then returns the ciphertext.
module aes_enc_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_text,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_text,
   output logic         busy,
   output logic [3:0]   round
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("aes_enc_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

   // Entry 0 sits in the top byte.
   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_t;

   fsm_t         fsm;
   logic [127:0] state_reg, key_reg, work_reg;
   logic [1:0]   col;
   logic [7:0]   rcon;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_TAB[{~a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 lives in the low byte of each column word, so tbox0 = {3s, s, s, 2s}.
   function automatic logic [31:0] tbox(input logic [1:0] rot, input logic [7:0] a);
      logic [7:0]  s, s2;
      logic [31:0] t;
      s  = sbox(a);
      s2 = xtime(s);
      t  = {s2 ^ s, s, s, s2};
      case (rot)
         2'd0:    return t;
         2'd1:    return {t[23:0], t[31:24]};
         2'd2:    return {t[15:0], t[31:16]};
         default: return {t[7:0], t[31:8]};
      endcase
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[32*c + 8*w +: 8] = s[32*((c + w) % 4) + 8*w +: 8];
         end
      end
      return r;
   endfunction

   // Next round key, combinational from the current one.
   logic [31:0]  rot_w3, sub_w3, nk0, nk1, nk2, nk3;
   logic [127:0] next_key;

   assign rot_w3   = {key_reg[103:96], key_reg[127:104]};
   assign sub_w3   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                      sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};
   assign nk0      = sub_w3 ^ key_reg[31:0] ^ {24'h0, rcon};
   assign nk1      = nk0 ^ key_reg[63:32];
   assign nk2      = nk1 ^ key_reg[95:64];
   assign nk3      = nk2 ^ key_reg[127:96];
   assign next_key = {nk3, nk2, nk1, nk0};

   logic [127:0] shifted, work_next;
   logic [1:0]   col_idx  [COLS_PER_CYCLE];
   logic [31:0]  col_word [COLS_PER_CYCLE];

   assign shifted = shift_rows(state_reg);

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      logic [31:0] sw, t0, t1, t2, t3;
      assign col_idx[k]  = col + 2'(k);
      assign sw          = shifted[{col_idx[k], 5'b0} +: 32];
      assign t0          = tbox(2'd0, sw[7:0]);
      assign t1          = tbox(2'd1, sw[15:8]);
      assign t2          = tbox(2'd2, sw[23:16]);
      assign t3          = tbox(2'd3, sw[31:24]);
      // The final round skips MixColumns: pick the plain S-box byte out of each T-box.
      assign col_word[k] = ((round == 4'd10) ? {t3[7:0], t2[7:0], t1[23:16], t0[23:16]}
                                             : (t0 ^ t1 ^ t2 ^ t3))
                           ^ next_key[{col_idx[k], 5'b0} +: 32];
   end

   always_comb begin
      work_next = work_reg;
      for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
         work_next[{col_idx[k], 5'b0} +: 32] = col_word[k];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm       <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_text  <= '0;
         busy      <= 1'b0;
         round     <= '0;
         state_reg <= '0;
         key_reg   <= '0;
         work_reg  <= '0;
         col       <= '0;
         rcon      <= '0;
      end else begin
         unique case (fsm)
            StIdle: begin
               if (in_valid) begin
                  state_reg <= in_text ^ in_key;
                  key_reg   <= in_key;
                  round     <= 4'd1;
                  col       <= '0;
                  rcon      <= 8'h01;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  fsm       <= StRound;
               end
            end
            StRound: begin
               work_reg <= work_next;
               col      <= col + COL_STEP;
               // state_reg is held until every column of this round has been read.
               if (col == COL_LAST) begin
                  state_reg <= work_next;
                  key_reg   <= next_key;
                  rcon      <= xtime(rcon);
                  col       <= '0;
                  if (round == 4'd10) begin
                     out_text  <= work_next;
                     out_valid <= 1'b1;
                     busy      <= 1'b0;
                     round     <= '0;
                     fsm       <= StDone;
                  end else begin
                     round <= round + 4'd1;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= StIdle;
               end
            end
            default: fsm <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: three widths (1, 2, 4 columns/cycle) checked against a byte-level
// AES-128 model, plus latency, round sequencing, backpressure, back-to-back and async reset.
module tb_aes_enc_iter;

   localparam logic [127:0] C1_KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] C1_PT   = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] C1_CT   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] ZERO_CT = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] in_text, in_key;
   logic         iv [3];
   logic         rd [3];
   logic         ov [3];
   logic         ordy [3];
   logic         bz [3];
   logic [3:0]   rnd [3];
   logic [127:0] ot [3];
   logic [7:0]   sb [256];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_enc_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clock    (clock),
         .reset    (reset),
         .in_valid (iv[g]),
         .in_ready (rd[g]),
         .in_text  (in_text),
         .in_key   (in_key),
         .out_valid(ov[g]),
         .out_ready(ordy[g]),
         .out_text (ot[g]),
         .busy     (bz[g]),
         .round    (rnd[g])
      );
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Textbook AES-128 on a 16-byte array (byte i = column i/4, row i%4).
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rk [16];
      logic [7:0]   rc, a0, a1, a2, a3, k0, k1, k2, k3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[8*i +: 8];
         s[i]  = pt[8*i +: 8] ^ rk[i];
      end
      for (int r = 1; r <= 10; r++) begin
         k0 = sb[rk[13]]; k1 = sb[rk[14]]; k2 = sb[rk[15]]; k3 = sb[rk[12]];
         rk[0] = rk[0] ^ k0 ^ rc;
         rk[1] = rk[1] ^ k1;
         rk[2] = rk[2] ^ k2;
         rk[3] = rk[3] ^ k3;
         for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
         rc = gmul(rc, 8'h02);
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input int g, input string tag);
      check($sformatf("%s_ctl_w%0d", tag, g), {rd[g], ov[g], bz[g], rnd[g]}, 7'b100_0000);
      check($sformatf("%s_text_w%0d", tag, g), ot[g], 128'h0);
   endtask

   // Offers one block, then follows the engine up to out_valid (bounded wait).
   task automatic transact(input int g, input logic [127:0] txt, input logic [127:0] key,
                           output logic [127:0] ct, output int lat, output int rmis);
      int n;
      n       = 4 >> g;
      in_text = txt;
      in_key  = key;
      iv[g]   = 1'b1;
      tick();
      iv[g] = 1'b0;
      lat   = -1;
      rmis  = 0;
      for (int e = 0; e <= 60; e++) begin
         if (ov[g]) begin
            lat = e;
            if (bz[g] !== 1'b0 || rnd[g] !== 4'd0 || rd[g] !== 1'b0) rmis++;
            break;
         end
         if (bz[g] !== 1'b1 || rnd[g] !== 4'(e / n + 1) || rd[g] !== 1'b0) rmis++;
         tick();
      end
      ct = ot[g];
   endtask

   task automatic handshake(input int g, input string tag);
      ordy[g] = 1'b1;
      tick();
      ordy[g] = 1'b0;
      check($sformatf("%s_release_w%0d", tag, g), {ov[g], rd[g]}, 2'b01);
   endtask

   task automatic run_check(input int g, input logic [127:0] txt, input logic [127:0] key,
                            input logic [127:0] exp, input string tag);
      logic [127:0] ct;
      int           lat, rmis;
      transact(g, txt, key, ct, lat, rmis);
      check($sformatf("%s_ct_w%0d", tag, g), ct, exp);
      check($sformatf("%s_latency_w%0d", tag, g), lat, 10 * (4 >> g));
      check($sformatf("%s_round_seq_w%0d", tag, g), rmis, 0);
      handshake(g, tag);
   endtask

   initial begin
      logic [127:0] pt, key, ct;
      int           lat, rmis, bad;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      reset   = 1'b1;
      in_text = '0;
      in_key  = '0;
      for (int g = 0; g < 3; g++) begin
         iv[g]   = 1'b0;
         ordy[g] = 1'b0;
      end
      #12;
      for (int g = 0; g < 3; g++) check_idle(g, "reset");
      reset = 1'b0;
      tick();

      for (int g = 0; g < 3; g++) run_check(g, C1_PT, C1_KEY, C1_CT, "c1");

      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 3; g++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_check(g, pt, key, aes_ref(pt, key), $sformatf("rand%0d", i));
         end
      end

      // Backpressure: hold the result, ignore a new offer.
      transact(0, C1_PT, C1_KEY, ct, lat, rmis);
      check("bp_ct", ct, C1_CT);
      bad = 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) begin
            in_text = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            iv[0]   = 1'b1;
         end
         tick();
         if (ot[0] !== ct || ov[0] !== 1'b1 || rd[0] !== 1'b0 || bz[0] !== 1'b0) bad++;
      end
      check("bp_hold", bad, 0);
      iv[0] = 1'b0;
      handshake(0, "bp");
      tick();
      check("bp_no_capture", {rd[0], bz[0], rnd[0]}, {1'b1, 1'b0, 4'd0});

      // Back-to-back with out_ready held high and in_valid held across the first block.
      ordy[0] = 1'b1;
      in_text = C1_PT;
      in_key  = C1_KEY;
      iv[0]   = 1'b1;
      tick();
      in_text = '0;
      in_key  = '0;
      repeat (40) tick();
      check("b2b_first_valid", ov[0], 1'b1);
      check("b2b_first_ct", ot[0], C1_CT);
      tick();
      check("b2b_first_release", {ov[0], rd[0]}, 2'b01);
      tick();
      check("b2b_second_accept", {rd[0], bz[0], rnd[0]}, {1'b0, 1'b1, 4'd1});
      iv[0] = 1'b0;
      repeat (40) tick();
      check("b2b_second_valid", ov[0], 1'b1);
      check("b2b_second_ct", ot[0], ZERO_CT);
      tick();
      check("b2b_second_release", {ov[0], rd[0]}, 2'b01);
      ordy[0] = 1'b0;

      // Asynchronous reset in the middle of round 5.
      in_text = C1_PT;
      in_key  = C1_KEY;
      iv[0]   = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (17) tick();
      check("mid_round", rnd[0], 4'd5);
      #2;
      reset = 1'b1;
      #1;
      check_idle(0, "async_reset");
      #1;
      reset = 1'b0;
      tick();
      run_check(0, C1_PT, C1_KEY, C1_CT, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
